reg_file_wb_arbiter: RTL and testbench
======================================

// Module: reg_file_wb_arbiter
// PURPOSE
//  Controller in front of Reg_file: shares its single write port (WE3/A3/WD3) between two writeback
//  requesters (EX = ALU results, MEM = load data) with valid/ready handshakes, and drives both read
//  addresses. Reg_file reads are registered, and a same-edge write is not visible in the read, so this
//  block forwards that write into the read data. Sits between the writeback stage and Reg_file.
// PARAMETERS
//  XLEN      32  data width
//  AW        5   register address width (2**AW registers; address 0 is hardwired zero)
//  ARB_MODE  0   0 = round-robin between EX/MEM, 1 = fixed priority MEM > EX
// PORTS
//  clk       in   1     clock, all state on rising edge
//  rst       in   1     reset, asynchronous, active-high
//  ex_valid  in   1     EX write request
//  ex_addr   in   AW    EX destination register
//  ex_data   in   XLEN  EX write data
//  ex_ready  out  1     EX request accepted this cycle
//  mem_valid in   1     MEM write request
//  mem_addr  in   AW    MEM destination register
//  mem_data  in   XLEN  MEM write data
//  mem_ready out  1     MEM request accepted this cycle
//  rd_a1     in   AW    read address 1, forwarded to Reg_file A1
//  rd_a2     in   AW    read address 2, forwarded to Reg_file A2
//  rf_rd1    in   XLEN  Reg_file RD1
//  rf_rd2    in   XLEN  Reg_file RD2
//  rf_a1     out  AW    to Reg_file A1 (= rd_a1)
//  rf_a2     out  AW    to Reg_file A2 (= rd_a2)
//  rf_we     out  1     to Reg_file WE3
//  rf_wa     out  AW    to Reg_file A3
//  rf_wd     out  XLEN  to Reg_file WD3
//  rd1       out  XLEN  corrected read data 1, one cycle after rd_a1
//  rd2       out  XLEN  corrected read data 2, one cycle after rd_a2
// BEHAVIOUR
//  - Handshake: a transfer occurs on an edge where valid && ready. Ready is combinational from the valid
//    inputs and the arbitration pointer. At most one ready per cycle. Requesters hold addr/data stable
//    until accepted. The block does not buffer requests.
//  - Arbitration: one valid -> it wins. Both valid -> ARB_MODE=1: MEM wins. ARB_MODE=0: winner is the
//    requester that did not win the last contested cycle. rr_last (1b) updates only on contested cycles.
//    Reset value of rr_last = EX, so the first contest goes to MEM.
//  - Write port: rf_wa/rf_wd = winner's addr/data (0 when no winner). rf_we = winner exists && addr != 0.
//    A write to x0 still handshakes (ready=1) but does not assert rf_we.
//  - Write latency: data is in Reg_file after the accepting edge. A read issued the next cycle sees it
//    directly.
//  - Bypass: at each edge, capture hitN <= rf_we && (rf_wa == rd_aN) and bdN <= rf_wd.
//    Then rdN = hitN ? bdN : rf_rdN. Read latency is 1 cycle. A read of x0 returns 0, because rf_we is
//    never set for x0.
//  - Both read ports hitting the same write: both forward.
//  - Reset (async, any cycle): rr_last=EX, hit1=hit2=0, bd1=bd2=0, so rd1/rd2 = rf_rd (Reg_file also
//    clears to 0). ex_ready/mem_ready/rf_we stay combinational, but must be 0 while rst=1.
//  - Reset mid-transfer: the in-flight request is dropped, with no write, and must be re-presented
//    after reset.
// STRUCTURE
//  - Shared package rf_pkg: XLEN, AW, ZERO_REG, and enum arb_mode_e {ARB_RR, ARB_FIXED_MEM}.
//  - One natural sub-module: rf_rr_arb2, a 2-requester round-robin/fixed arbiter with a pointer and
//    one-hot grant. The bypass and muxing stay in the top.
//  - Integration test wraps this block together with Reg_file.
// TESTING
//  1 Reset: rst=1 mid-run with ex_valid=1 -> ex_ready=0, rf_we=0, rd1=rd2=0; after release, the first
//    contested cycle grants MEM.
//  2 Single write: ex_valid=1, ex_addr=5, ex_data=32'hDEAD_BEEF -> ex_ready=1, rf_we=1, rf_wa=5; next
//    cycle rd_a1=5 -> rd1=DEAD_BEEF the following cycle.
//  3 Same-cycle bypass: a mem write of x7=32'h1234 and rd_a1=rd_a2=7 in the same cycle -> next cycle
//    rd1=rd2=32'h1234. Note that Reg_file RD1 alone would show the old value.
//  4 Contention, ARB_MODE=0: both valid for 4 cycles (EX→x1/x2, MEM→x3/x4, each held until accepted) ->
//    grants alternate MEM, EX, MEM, EX; final x1..x4 hold the expected data. ARB_MODE=1: MEM drains first.
//  5 x0 write: ex_valid=1, ex_addr=0, data=32'hFFFF_FFFF -> ex_ready=1, rf_we=0; rd_a1=0 -> rd1=0.
//  6 Bypass miss: write x9 while reading rd_a1=10 -> rd1 = old x10 value; hit1=0.

Source files
------------

// File: rtl/rf_pkg.sv
// Shared widths, register-zero constant and arbitration enums for the
// Reg_file writeback arbiter.
package rf_pkg;

  localparam int XLEN = 32;
  localparam int AW   = 5;

  localparam logic [AW-1:0] ZERO_REG = {AW{1'b0}};

  typedef enum logic {
    ARB_RR        = 1'b0,
    ARB_FIXED_MEM = 1'b1
  } arb_mode_e;

  // Identifies the winner of the most recent contested cycle.
  typedef enum logic {
    REQ_EX  = 1'b0,
    REQ_MEM = 1'b1
  } req_e;

  localparam int GNT_EX  = 0;
  localparam int GNT_MEM = 1;

endpackage

// File: rtl/reg_file_wb_arbiter_if.sv
// Bundle of writeback handshakes, read addresses and Reg_file port signals
// seen by reg_file_wb_arbiter; slave is the arbiter side.
interface reg_file_wb_arbiter_if;
  import rf_pkg::*;

  logic            ex_valid;
  logic [AW-1:0]   ex_addr;
  logic [XLEN-1:0] ex_data;
  logic            ex_ready;
  logic            mem_valid;
  logic [AW-1:0]   mem_addr;
  logic [XLEN-1:0] mem_data;
  logic            mem_ready;
  logic [AW-1:0]   rd_a1;
  logic [AW-1:0]   rd_a2;
  logic [XLEN-1:0] rf_rd1;
  logic [XLEN-1:0] rf_rd2;
  logic [AW-1:0]   rf_a1;
  logic [AW-1:0]   rf_a2;
  logic            rf_we;
  logic [AW-1:0]   rf_wa;
  logic [XLEN-1:0] rf_wd;
  logic [XLEN-1:0] rd1;
  logic [XLEN-1:0] rd2;

  modport slave (
    input  ex_valid, ex_addr, ex_data, mem_valid, mem_addr, mem_data,
    input  rd_a1, rd_a2, rf_rd1, rf_rd2,
    output ex_ready, mem_ready, rf_a1, rf_a2, rf_we, rf_wa, rf_wd, rd1, rd2
  );

  modport master (
    output ex_valid, ex_addr, ex_data, mem_valid, mem_addr, mem_data,
    output rd_a1, rd_a2, rf_rd1, rf_rd2,
    input  ex_ready, mem_ready, rf_a1, rf_a2, rf_we, rf_wa, rf_wd, rd1, rd2
  );

endinterface

// File: rtl/rf_rr_arb2.sv
// Two-requester arbiter (bit 0 = EX, bit 1 = MEM) with one-hot grant,
// round-robin or fixed MEM priority; grant is forced low during reset.
module rf_rr_arb2
  import rf_pkg::*;
#(
  parameter arb_mode_e ARB_MODE = ARB_RR
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  output logic [1:0] gnt
);

  req_e rr_last_r;
  req_e rr_next_s;

  // Grant selection and pointer update; the pointer moves only on contested cycles
  always_comb begin
    gnt       = 2'b00;
    rr_next_s = rr_last_r;
    if (rst) begin
      gnt = 2'b00;
    end else begin
      case (req)
        2'b01:   gnt = 2'b01;
        2'b10:   gnt = 2'b10;
        2'b11: begin
          if ((ARB_MODE == ARB_FIXED_MEM) || (rr_last_r == REQ_EX)) begin
            gnt       = 2'b10;
            rr_next_s = REQ_MEM;
          end else begin
            gnt       = 2'b01;
            rr_next_s = REQ_EX;
          end
        end
        default: gnt = 2'b00;
      endcase
    end
  end

  // Last contested winner
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_last_r <= REQ_EX;
    end else begin
      rr_last_r <= rr_next_s;
    end
  end

endmodule

// File: rtl/reg_file_wb_arbiter.sv
// Shares the Reg_file write port between EX and MEM writeback and forwards a
// same-edge write into the registered read data.
module reg_file_wb_arbiter
  import rf_pkg::*;
#(
  parameter arb_mode_e ARB_MODE = ARB_RR
) (
  input  logic                 clk,
  input  logic                 rst,
  reg_file_wb_arbiter_if.slave bus
);

  logic [1:0]      gnt_s;
  logic [AW-1:0]   wa_s;
  logic [XLEN-1:0] wd_s;
  logic            hit1_r;
  logic            hit2_r;
  logic [XLEN-1:0] bd1_r;
  logic [XLEN-1:0] bd2_r;

  rf_rr_arb2 #(.ARB_MODE(ARB_MODE)) u_arb (
    .clk (clk),
    .rst (rst),
    .req ({bus.mem_valid, bus.ex_valid}),
    .gnt (gnt_s)
  );

  // Write-port mux driven by the one-hot grant
  always_comb begin
    wa_s = ZERO_REG;
    wd_s = {XLEN{1'b0}};
    case (gnt_s)
      2'b01: begin
        wa_s = bus.ex_addr;
        wd_s = bus.ex_data;
      end
      2'b10: begin
        wa_s = bus.mem_addr;
        wd_s = bus.mem_data;
      end
      default: begin
        wa_s = ZERO_REG;
        wd_s = {XLEN{1'b0}};
      end
    endcase
  end

  assign bus.ex_ready  = gnt_s[GNT_EX];
  assign bus.mem_ready = gnt_s[GNT_MEM];
  // x0 writes still handshake but never reach the array, so reads of x0 stay 0
  assign bus.rf_we     = (gnt_s != 2'b00) && (wa_s != ZERO_REG);
  assign bus.rf_wa     = wa_s;
  assign bus.rf_wd     = wd_s;
  assign bus.rf_a1     = bus.rd_a1;
  assign bus.rf_a2     = bus.rd_a2;

  // Capture a write that lands on the same edge as a read of that register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hit1_r <= 1'b0;
      hit2_r <= 1'b0;
      bd1_r  <= {XLEN{1'b0}};
      bd2_r  <= {XLEN{1'b0}};
    end else begin
      hit1_r <= bus.rf_we && (bus.rf_wa == bus.rd_a1);
      hit2_r <= bus.rf_we && (bus.rf_wa == bus.rd_a2);
      bd1_r  <= bus.rf_wd;
      bd2_r  <= bus.rf_wd;
    end
  end

  assign bus.rd1 = hit1_r ? bd1_r : bus.rf_rd1;
  assign bus.rd2 = hit2_r ? bd2_r : bus.rf_rd2;

endmodule

// File: tb/tb_reg_file_wb_arbiter.sv
// Directed bench: two arbiter instances (round-robin and fixed MEM priority),
// each in front of a small registered-read register file model.
module tb_reg_file_wb_arbiter;
  import rf_pkg::*;

  logic clk;
  logic rst;
  int   tests_run;
  int   fails;

  reg_file_wb_arbiter_if b0 ();
  reg_file_wb_arbiter_if b1 ();

  reg_file_wb_arbiter #(.ARB_MODE(ARB_RR)) u0 (
    .clk (clk),
    .rst (rst),
    .bus (b0)
  );

  reg_file_wb_arbiter #(.ARB_MODE(ARB_FIXED_MEM)) u1 (
    .clk (clk),
    .rst (rst),
    .bus (b1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [XLEN-1:0] regs0 [32];
  logic [XLEN-1:0] regs1 [32];

  // Reg_file model: registered reads that see the pre-edge contents
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) begin
        regs0[i] <= 32'h0;
        regs1[i] <= 32'h0;
      end
      b0.rf_rd1 <= 32'h0;
      b0.rf_rd2 <= 32'h0;
      b1.rf_rd1 <= 32'h0;
      b1.rf_rd2 <= 32'h0;
    end else begin
      b0.rf_rd1 <= regs0[b0.rf_a1];
      b0.rf_rd2 <= regs0[b0.rf_a2];
      b1.rf_rd1 <= regs1[b1.rf_a1];
      b1.rf_rd2 <= regs1[b1.rf_a2];
      if (b0.rf_we) regs0[b0.rf_wa] <= b0.rf_wd;
      if (b1.rf_we) regs1[b1.rf_wa] <= b1.rf_wd;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ex0(input logic v, input logic [4:0] a, input logic [31:0] d);
    b0.ex_valid = v; b0.ex_addr = a; b0.ex_data = d;
  endtask

  task automatic mem0(input logic v, input logic [4:0] a, input logic [31:0] d);
    b0.mem_valid = v; b0.mem_addr = a; b0.mem_data = d;
  endtask

  task automatic ex1(input logic v, input logic [4:0] a, input logic [31:0] d);
    b1.ex_valid = v; b1.ex_addr = a; b1.ex_data = d;
  endtask

  task automatic mem1(input logic v, input logic [4:0] a, input logic [31:0] d);
    b1.mem_valid = v; b1.mem_addr = a; b1.mem_data = d;
  endtask

  initial begin
    tests_run = 0;
    fails     = 0;
    rst       = 1'b1;
    ex0(1'b0, 5'd0, 32'h0);  mem0(1'b0, 5'd0, 32'h0);
    ex1(1'b0, 5'd0, 32'h0);  mem1(1'b0, 5'd0, 32'h0);
    b0.rd_a1 = 5'd0; b0.rd_a2 = 5'd0;
    b1.rd_a1 = 5'd0; b1.rd_a2 = 5'd0;
    tick();
    tick();
    rst = 1'b0;
    tick();

    // Single EX write to x5, read back next cycle
    ex0(1'b1, 5'd5, 32'hDEAD_BEEF);
    #1;
    check("wr_ex_ready",  32'(b0.ex_ready),  32'h1);
    check("wr_mem_ready", 32'(b0.mem_ready), 32'h0);
    check("wr_rf_we",     32'(b0.rf_we),     32'h1);
    check("wr_rf_wa",     32'(b0.rf_wa),     32'h5);
    check("wr_rf_wd",     b0.rf_wd,          32'hDEAD_BEEF);
    tick();
    ex0(1'b0, 5'd0, 32'h0);
    b0.rd_a1 = 5'd5;
    #1;
    check("wr_rf_a1", 32'(b0.rf_a1), 32'h5);
    tick();
    check("wr_rd1", b0.rd1, 32'hDEAD_BEEF);

    // Same-edge MEM write of x7 forwarded to both read ports
    mem0(1'b1, 5'd7, 32'h0000_1234);
    b0.rd_a1 = 5'd7; b0.rd_a2 = 5'd7;
    #1;
    check("byp_mem_ready", 32'(b0.mem_ready), 32'h1);
    check("byp_ex_ready",  32'(b0.ex_ready),  32'h0);
    check("byp_rf_we",     32'(b0.rf_we),     32'h1);
    tick();
    mem0(1'b0, 5'd0, 32'h0);
    check("byp_rd1", b0.rd1, 32'h0000_1234);
    check("byp_rd2", b0.rd2, 32'h0000_1234);

    // Bypass miss: write x9 while port 1 reads x10, port 2 reads x9
    ex0(1'b1, 5'd10, 32'h5555_0010);
    tick();
    ex0(1'b1, 5'd9, 32'hAAAA_0009);
    b0.rd_a1 = 5'd10; b0.rd_a2 = 5'd9;
    tick();
    ex0(1'b0, 5'd0, 32'h0);
    check("miss_rd1",  b0.rd1, 32'h5555_0010);
    check("miss_rd2",  b0.rd2, 32'hAAAA_0009);
    check("miss_hit1", 32'(u0.hit1_r), 32'h0);

    // x0 write handshakes but does not write
    ex0(1'b1, 5'd0, 32'hFFFF_FFFF);
    b0.rd_a1 = 5'd0;
    #1;
    check("x0_ex_ready", 32'(b0.ex_ready), 32'h1);
    check("x0_rf_we",    32'(b0.rf_we),    32'h0);
    tick();
    ex0(1'b0, 5'd0, 32'h0);
    check("x0_rd1", b0.rd1, 32'h0);

    // Contest before reset: MEM first, then EX
    ex0(1'b1, 5'd11, 32'h0000_0B0B);
    mem0(1'b1, 5'd12, 32'h0000_0C0C);
    #1;
    check("pre_c1_mem_ready", 32'(b0.mem_ready), 32'h1);
    check("pre_c1_ex_ready",  32'(b0.ex_ready),  32'h0);
    tick();
    mem0(1'b1, 5'd14, 32'h0000_0E0E);
    #1;
    check("pre_c2_ex_ready",  32'(b0.ex_ready),  32'h1);
    check("pre_c2_mem_ready", 32'(b0.mem_ready), 32'h0);

    // Reset mid-transfer with EX pending
    rst = 1'b1;
    #1;
    check("rst_ex_ready",  32'(b0.ex_ready),  32'h0);
    check("rst_mem_ready", 32'(b0.mem_ready), 32'h0);
    check("rst_rf_we",     32'(b0.rf_we),     32'h0);
    check("rst_rd1",       b0.rd1,            32'h0);
    check("rst_rd2",       b0.rd2,            32'h0);
    tick();
    tick();
    check("rst_hold_ex_ready", 32'(b0.ex_ready), 32'h0);

    // Round-robin contention after release: MEM, EX, MEM, EX
    rst = 1'b0;
    ex0(1'b1, 5'd1, 32'h1111_0001);
    mem0(1'b1, 5'd3, 32'h3333_0003);
    #1;
    check("rr_c1_mem_ready", 32'(b0.mem_ready), 32'h1);
    check("rr_c1_ex_ready",  32'(b0.ex_ready),  32'h0);
    tick();
    mem0(1'b1, 5'd4, 32'h4444_0004);
    #1;
    check("rr_c2_ex_ready",  32'(b0.ex_ready),  32'h1);
    check("rr_c2_mem_ready", 32'(b0.mem_ready), 32'h0);
    tick();
    ex0(1'b1, 5'd2, 32'h2222_0002);
    #1;
    check("rr_c3_mem_ready", 32'(b0.mem_ready), 32'h1);
    check("rr_c3_ex_ready",  32'(b0.ex_ready),  32'h0);
    tick();
    mem0(1'b0, 5'd0, 32'h0);
    #1;
    check("rr_c4_ex_ready", 32'(b0.ex_ready), 32'h1);
    tick();
    ex0(1'b0, 5'd0, 32'h0);
    b0.rd_a1 = 5'd1; b0.rd_a2 = 5'd2;
    tick();
    check("rr_x1", b0.rd1, 32'h1111_0001);
    check("rr_x2", b0.rd2, 32'h2222_0002);
    b0.rd_a1 = 5'd11; b0.rd_a2 = 5'd3;
    tick();
    check("rr_x11_dropped", b0.rd1, 32'h0);
    check("rr_x3",          b0.rd2, 32'h3333_0003);
    b0.rd_a1 = 5'd4;
    tick();
    check("rr_x4", b0.rd1, 32'h4444_0004);

    // Fixed priority: MEM drains before EX
    ex1(1'b1, 5'd1, 32'h1111_0001);
    mem1(1'b1, 5'd3, 32'h3333_0003);
    #1;
    check("fx_c1_mem_ready", 32'(b1.mem_ready), 32'h1);
    tick();
    mem1(1'b1, 5'd4, 32'h4444_0004);
    #1;
    check("fx_c2_mem_ready", 32'(b1.mem_ready), 32'h1);
    check("fx_c2_ex_ready",  32'(b1.ex_ready),  32'h0);
    tick();
    mem1(1'b0, 5'd0, 32'h0);
    #1;
    check("fx_c3_ex_ready", 32'(b1.ex_ready), 32'h1);
    tick();
    ex1(1'b1, 5'd2, 32'h2222_0002);
    #1;
    check("fx_c4_ex_ready", 32'(b1.ex_ready), 32'h1);
    tick();
    ex1(1'b0, 5'd0, 32'h0);
    b1.rd_a1 = 5'd1; b1.rd_a2 = 5'd4;
    tick();
    check("fx_x1", b1.rd1, 32'h1111_0001);
    check("fx_x4", b1.rd2, 32'h4444_0004);

    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
